uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
Upstream stage of top_UART. Buffers bytes from a producer in a small FIFO and drains them one at a time through the UART register interface. For each byte it performs a data-register write, then a control-register "send" write, then polls the control register until the UART self-clears the send bit. Provides flow control (full/empty/count) to the producer.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
SEND_CMD, 8'h01, value written to the control register to start transmission; bit 0 is the send/busy bit
TIMEOUT_CYCLES, 100000, poll cycles before abort (used only with the optional feature)

Ports:
clk_i  in  1  system clock, rising edge
reset_i  in  1  synchronous, active-low reset
push_i  in  1  producer write strobe
push_data_i  in  8  byte to enqueue
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a push was dropped
busy_o  out  1  FSM not in IDLE
done_o  out  1  one-cycle pulse per byte handed off
uart_reg_sel_o  out  1  to top_UART reg_sel_i: 1 = data register, 0 = control register
uart_wr_o  out  1  to top_UART wr_i
uart_data_o  out  8  to top_UART data_in
uart_ctrl_i  in  8  from top_UART data_out (control-register readback while reg_sel=0)

Behaviour:
- Reset (reset_i=0 at a rising edge): FIFO pointers and count 0, state IDLE. Outputs after that edge: full_o=0, empty_o=1, count_o=0, overflow_o=0, busy_o=0, done_o=0, uart_reg_sel_o=0, uart_wr_o=0, uart_data_o=0. Reset mid-transfer aborts the transfer and discards all queued bytes; no further UART writes occur.
- FIFO: circular buffer with wrapping pointers. A push is accepted only when full_o=0.
  - Push while full is dropped and sets overflow_o, which clears only on reset. This holds even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves count unchanged.
- FSM states and per-state outputs (all UART outputs are decoded from the registered state):
  - IDLE: reg_sel=0, wr=0. Goes to LOAD when empty_o=0.
  - LOAD: reg_sel=1, wr=1, data=FIFO head. Always goes to SEND.
  - SEND: reg_sel=0, wr=1, data=SEND_CMD. Always goes to SETTLE.
  - SETTLE: reg_sel=0, wr=0. One cycle that absorbs UART readback latency. Always goes to POLL.
  - POLL: reg_sel=0, wr=0. Samples uart_ctrl_i[0] every cycle. Stays while the bit is 1. When it reads 0: pop the FIFO head, pulse done_o in the cycle after that edge, go to IDLE.
- Latency: a push in cycle N into an empty, idle block gives LOAD in cycle N+2 and SEND in N+3. The minimum per-byte cost is 5 cycles.
- uart_data_o holds 0 outside LOAD and SEND.
- The FIFO head is popped only after POLL completes, so the byte stays visible in LOAD until the handoff is confirmed.
- count_o, full_o and empty_o reflect the registered state and update one edge after a push or pop.

Optional Feature:
Macro UART_TX_FEEDER_TIMEOUT_EN.
- With the macro defined:
  - A poll counter resets on POLL entry.
  - If it reaches TIMEOUT_CYCLES while bit 0 is still 1, the FSM pops the byte without pulsing done_o and returns to IDLE.
  - The added output timeout_o (1 bit) is set and stays sticky until reset.
- Without the macro: no counter, no timeout_o port, and POLL waits indefinitely.

Decomposition:
- Package uart_pkg: state enum (IDLE, LOAD, SEND, SETTLE, POLL); localparams REG_SEL_DATA=1, REG_SEL_CTRL=0, CTRL_SEND_BIT=0.
- Sub-module sync_fifo, parameterised on DEPTH and WIDTH=8. It exposes push, pop, head, full, empty, count and overflow. The top level holds the FSM and the UART interface.

Test Plan:
- Reset then idle: after reset_i=0 for 2 cycles, then 1 -> empty_o=1, count_o=0, uart_wr_o=0 for 20 cycles.
- Single byte: push 8'h55 in cycle N; UART model holds ctrl[0]=1 for 10 cycles after the SEND write -> LOAD in N+2 (reg_sel=1, wr=1, data=8'h55), SEND in N+3 (reg_sel=0, wr=1, data=8'h01). done_o pulses once, 1 cycle after ctrl[0] is seen 0. count_o returns to 0.
- Burst and full: push 9 bytes 8'h00..8'h08 back-to-back with DEPTH=8 and a stalled UART -> full_o=1 after 8 pushes, 9th dropped, overflow_o=1. After release, UART data writes are 8'h00..8'h07 in order and pointers wrap.
- Simultaneous push and pop: with count=3, push in the same cycle as a POLL completion -> count stays 3 and the new byte is appended at the tail.
- Reset mid-transfer: assert reset_i=0 during POLL with 4 bytes queued -> next cycle busy_o=0, count_o=0, no further uart_wr_o pulses.
- With UART_TX_FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=16, and ctrl[0] stuck at 1 -> timeout_o=1 after 16 POLL cycles, byte discarded, no done_o, next byte's LOAD follows.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmit feeder: FSM state
//                encoding and UART register-interface constants.
//  Contents    : state_t and ST_* state codes, REG_SEL_DATA / REG_SEL_CTRL
//                register selects, CTRL_SEND_BIT (send/busy bit position).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SEND   = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_POLL   = 3'd4;

    localparam logic REG_SEL_DATA  = 1'b1;
    localparam logic REG_SEL_CTRL  = 1'b0;
    localparam int   CTRL_SEND_BIT = 0;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock circular-buffer FIFO with registered flags and
//                a sticky overflow indicator.
//  Ports       : clk_i, reset_i (sync, active-low)
//                push_i/push_data_i - enqueue, ignored while full
//                pop_i              - dequeue, ignored while empty
//                head_o             - oldest entry (valid while !empty_o)
//                full_o, empty_o, count_o - occupancy
//                overflow_o         - sticky, set by a push while full
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    // A push is judged against the registered full flag, so a pop in the
    // same cycle does not rescue a push into a full FIFO.
    assign w_do_push = push_i && !w_full;
    assign w_do_pop  = pop_i && !w_empty;

    // Storage carries no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (push_i && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign head_o     = r_mem[r_rd_ptr];
    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_feeder
//  Description : Buffers producer bytes in a FIFO and hands them one at a time
//                to the UART register interface: data-register write, control
//                "send" write, one settle cycle, then poll the control
//                register until the UART clears the send bit.
//  Ports       : clk_i, reset_i (sync, active-low)
//                push_i/push_data_i, full_o, empty_o, count_o, overflow_o
//                busy_o (FSM not idle), done_o (pulse per byte handed off)
//                uart_reg_sel_o, uart_wr_o, uart_data_o, uart_ctrl_i
//                timeout_o (only with UART_TX_FEEDER_TIMEOUT_EN)
//  Options     : `define UART_TX_FEEDER_TIMEOUT_EN adds a poll timeout that
//                drops the stuck byte and raises sticky timeout_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int         DEPTH          = 8,
    parameter logic [7:0] SEND_CMD       = 8'h01,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    push_i,
    input  logic [7:0]              push_data_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    uart_reg_sel_o,
    output logic                    uart_wr_o,
    output logic [7:0]              uart_data_o,
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    output logic                    timeout_o,
`endif
    input  logic [7:0]              uart_ctrl_i
);

    state_t     r_state;
    logic       r_done;
    logic       w_pop;
    logic       w_poll_ok;
    logic [7:0] w_head;
    logic       w_empty;
    logic       w_unused_ctrl;

    // Only the send/busy bit of the control readback matters here.
    assign w_unused_ctrl = ^{uart_ctrl_i[7:CTRL_SEND_BIT+1]};

    assign w_poll_ok = (r_state == ST_POLL) && !uart_ctrl_i[CTRL_SEND_BIT];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (full_o),
        .empty_o     (w_empty),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_poll_cnt;
    logic              r_timeout;
    logic              w_timeout_hit;

    // r_poll_cnt equals the number of POLL cycles already spent, so the hit
    // lands on the TIMEOUT_CYCLES-th POLL cycle.
    assign w_timeout_hit = (r_state == ST_POLL) && uart_ctrl_i[CTRL_SEND_BIT]
                        && (r_poll_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
    assign w_pop         = w_poll_ok || w_timeout_hit;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_poll_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == ST_SETTLE) begin
                r_poll_cnt <= '0;
            end else if (r_state == ST_POLL) begin
                r_poll_cnt <= r_poll_cnt + c_TO_W'(1);
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_pop            = w_poll_ok;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            // done marks a confirmed handoff only, never a timeout drop.
            r_done <= w_poll_ok;
            case (r_state)
                ST_IDLE:   if (!w_empty) r_state <= ST_LOAD;
                ST_LOAD:   r_state <= ST_SEND;
                ST_SEND:   r_state <= ST_SETTLE;
                ST_SETTLE: r_state <= ST_POLL;
                ST_POLL:   if (w_pop) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // UART outputs decode straight from the registered state.
    always_comb begin
        uart_reg_sel_o = REG_SEL_CTRL;
        uart_wr_o      = 1'b0;
        uart_data_o    = 8'h00;
        case (r_state)
            ST_LOAD: begin
                uart_reg_sel_o = REG_SEL_DATA;
                uart_wr_o      = 1'b1;
                uart_data_o    = w_head;
            end
            ST_SEND: begin
                uart_wr_o   = 1'b1;
                uart_data_o = SEND_CMD;
            end
            default: ;
        endcase
    end

    assign empty_o = w_empty;
    assign busy_o  = (r_state != ST_IDLE);
    assign done_o  = r_done;

endmodule : uart_tx_feeder
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_feeder
//  Description : Self-checking bench for uart_tx_feeder. Directed stimulus
//                pushes expected data-register bytes into a scoreboard queue;
//                a monitor pops and compares on every UART write. A small
//                UART model holds the send bit busy after each SEND write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       push_i = 1'b0;
    logic [7:0] push_data_i = 8'h00;
    logic       full_o, empty_o, overflow_o, busy_o, done_o;
    logic [3:0] count_o;
    logic       uart_reg_sel_o, uart_wr_o;
    logic [7:0] uart_data_o;
    logic [7:0] uart_ctrl_i;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    logic       timeout_o;
`endif

    uart_tx_feeder #(
        .DEPTH          (DEPTH),
        .SEND_CMD       (8'h01),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .push_i         (push_i),
        .push_data_i    (push_data_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .uart_reg_sel_o (uart_reg_sel_o),
        .uart_wr_o      (uart_wr_o),
        .uart_data_o    (uart_data_o),
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        .timeout_o      (timeout_o),
`endif
        .uart_ctrl_i    (uart_ctrl_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    logic [7:0] exp_q[$];

    // UART model: send bit reads 1 for 'stall' cycles after a SEND write,
    // or permanently while 'hold' is set.
    logic hold  = 1'b0;
    int   stall = 0;
    int   busy_cnt = 0;

    always @(posedge clk) begin
        if (!reset_i)
            busy_cnt <= 0;
        else if (uart_wr_o && !uart_reg_sel_o && uart_data_o[0])
            busy_cnt <= stall;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end

    assign uart_ctrl_i = {7'd0, (hold || (busy_cnt > 0))};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset_i) begin
            if (uart_wr_o) begin
                wr_cnt++;
                if (uart_reg_sel_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_write: got %0h expected none", uart_data_o);
                    end else begin
                        check("sb_data", {24'd0, uart_data_o}, {24'd0, exp_q.pop_front()});
                    end
                end else begin
                    check("send_cmd", {24'd0, uart_data_o}, 32'h01);
                end
            end else begin
                check("data_idle_zero", {24'd0, uart_data_o}, 32'h0);
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        push_i      = 1'b1;
        push_data_i = b;
        if (accept) exp_q.push_back(b);
        tick();
        push_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((count_o != 0 || busy_o) && n < max) begin
            tick();
            n++;
        end
        check({name, "_drain_bound"}, (n < max) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;

        // Reset then idle
        reset_i = 1'b0;
        repeat (2) tick();
        check("rst_full",     full_o,         0);
        check("rst_empty",    empty_o,        1);
        check("rst_count",    count_o,        0);
        check("rst_overflow", overflow_o,     0);
        check("rst_busy",     busy_o,         0);
        check("rst_done",     done_o,         0);
        check("rst_reg_sel",  uart_reg_sel_o, 0);
        check("rst_wr",       uart_wr_o,      0);
        check("rst_data",     uart_data_o,    0);
        reset_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_empty", empty_o,   1);
            check("idle_count", count_o,   0);
            check("idle_wr",    uart_wr_o, 0);
        end

        // Single byte, UART busy for 10 cycles after SEND
        stall = 10;
        d0 = done_cnt;
        push(8'h55, 1'b1);                         // now in cycle N+1
        check("single_count_n1", count_o, 1);
        check("single_busy_n1",  busy_o,  0);
        tick();                                    // N+2: LOAD
        check("load_reg_sel", uart_reg_sel_o, 1);
        check("load_wr",      uart_wr_o,      1);
        check("load_data",    uart_data_o,    8'h55);
        tick();                                    // N+3: SEND
        check("send_reg_sel", uart_reg_sel_o, 0);
        check("send_wr",      uart_wr_o,      1);
        check("send_data",    uart_data_o,    8'h01);
        repeat (11) tick();                        // N+14: last POLL, ctrl=0
        check("single_done_early", done_o, 0);
        check("single_busy_poll",  busy_o, 1);
        tick();                                    // N+15: done pulse
        check("single_done",  done_o,  1);
        check("single_count", count_o, 0);
        check("single_idle",  busy_o,  0);
        tick();
        check("single_done_once", done_o, 0);
        check("single_done_cnt",  done_cnt - d0, 1);

        // Burst into a stalled UART: fill, overflow, then drain in order
        stall = 0;
        hold  = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) begin
            push(8'(i), (i < 8));
            if (i == 6) check("burst_not_full_7", full_o, 0);
            if (i == 7) check("burst_full_8",     full_o, 1);
        end
        check("burst_full",     full_o,     1);
        check("burst_count",    count_o,    8);
        check("burst_overflow", overflow_o, 1);
        hold = 1'b0;
        wait_drain("burst", 200);
        tick();
        check("burst_done_cnt",   done_cnt - d0, 8);
        check("burst_ovf_sticky", overflow_o, 1);
        check("burst_sb_empty",   exp_q.size(), 0);

        // Simultaneous push and pop at count=3
        hold = 1'b1;
        d0 = done_cnt;
        push(8'hA0, 1'b1);
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        repeat (6) tick();
        check("pp_count_before", count_o, 3);
        check("pp_busy",         busy_o,  1);
        hold = 1'b0;                               // POLL sees 0 at this edge
        push(8'hA3, 1'b1);
        check("pp_count_after", count_o, 3);
        check("pp_done",        done_o,  1);
        wait_drain("pp", 200);
        tick();
        check("pp_done_cnt", done_cnt - d0, 4);

        // Reset mid-transfer
        hold = 1'b1;
        push(8'hB0, 1'b1);
        push(8'hB1, 1'b1);
        push(8'hB2, 1'b1);
        push(8'hB3, 1'b1);
        repeat (6) tick();
        check("mid_busy_before", busy_o, 1);
        reset_i = 1'b0;
        tick();
        exp_q.delete();
        check("mid_busy",     busy_o,     0);
        check("mid_count",    count_o,    0);
        check("mid_empty",    empty_o,    1);
        check("mid_overflow", overflow_o, 0);
        reset_i = 1'b1;
        w0 = wr_cnt;
        repeat (20) tick();
        check("mid_no_writes", wr_cnt - w0, 0);
        hold = 1'b0;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
        // Poll timeout with send bit stuck
        check("to_initial", timeout_o, 0);
        hold = 1'b1;
        d0 = done_cnt;
        push(8'hC0, 1'b1);                         // cycle N
        push(8'hC1, 1'b1);                         // now in N+2 (LOAD C0)
        repeat (18) tick();                        // N+20: 16th POLL cycle
        check("to_not_yet", timeout_o, 0);
        tick();                                    // N+21
        check("to_set",      timeout_o, 1);
        check("to_count",    count_o,   1);
        check("to_no_done",  done_o,    0);
        tick();                                    // N+22: LOAD C1
        check("to_next_load", uart_reg_sel_o, 1);
        hold = 1'b0;
        wait_drain("to", 100);
        tick();
        check("to_done_cnt", done_cnt - d0, 1);
        check("to_sticky",   timeout_o, 1);
`endif

        check("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_feeder
`default_nettype wire
